// File: rtl/vend_change_sequencer.sv
// Coin-return sequencer: pays a change amount (nickel units) one coin at a time,
// largest coin first, against a per-coin inventory. Optional macro: VEND_CHANGE_STATS_EN.
module vend_change_sequencer #(
  parameter int AMT_W            = 4,
  parameter int CNT_W            = 6,
  parameter int INIT_NICKELS     = 10,
  parameter int INIT_DIMES       = 10,
  parameter int INIT_DOUBLEDIMES = 10,
  parameter int PULSE_GAP        = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             refill,
  output logic             give_nickel,
  output logic             give_dime,
  output logic             give_doubledime,
  output logic             done,
  output logic             short,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt,
  output logic [CNT_W-1:0] doubledime_cnt
`ifdef VEND_CHANGE_STATS_EN
  ,
  output logic [15:0]      paid_total,
  output logic [7:0]       short_total
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_PULSE, ST_GAP, ST_DONE, ST_SHORT
  } state_e;

  typedef enum logic [1:0] {
    COIN_NICKEL, COIN_DIME, COIN_DOUBLEDIME
  } coin_e;

  localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((PULSE_GAP > 0) ? PULSE_GAP - 1 : 0);

  localparam logic [AMT_W-1:0] VAL_NICKEL     = AMT_W'(1);
  localparam logic [AMT_W-1:0] VAL_DIME       = AMT_W'(2);
  localparam logic [AMT_W-1:0] VAL_DOUBLEDIME = AMT_W'(4);

  state_e           state_q, state_d;
  coin_e            coin_q, coin_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] nickel_q, nickel_d;
  logic [CNT_W-1:0] dime_q, dime_d;
  logic [CNT_W-1:0] doubledime_q, doubledime_d;

  function automatic logic [AMT_W-1:0] coin_value(coin_e c);
    case (c)
      COIN_DOUBLEDIME: coin_value = VAL_DOUBLEDIME;
      COIN_DIME:       coin_value = VAL_DIME;
      default:         coin_value = VAL_NICKEL;
    endcase
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      coin_q       <= COIN_NICKEL;
      remaining_q  <= '0;
      gap_q        <= '0;
      nickel_q     <= CNT_W'(INIT_NICKELS);
      dime_q       <= CNT_W'(INIT_DIMES);
      doubledime_q <= CNT_W'(INIT_DOUBLEDIMES);
    end else begin
      state_q      <= state_d;
      coin_q       <= coin_d;
      remaining_q  <= remaining_d;
      gap_q        <= gap_d;
      nickel_q     <= nickel_d;
      dime_q       <= dime_d;
      doubledime_q <= doubledime_d;
    end
  end

  // NOTE: every signal driven here gets a hold-value default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    coin_d       = coin_q;
    remaining_d  = remaining_q;
    gap_d        = gap_q;
    nickel_d     = nickel_q;
    dime_d       = dime_q;
    doubledime_d = doubledime_q;

    unique case (state_q)
      ST_IDLE: begin
        if (refill) begin
          nickel_d     = CNT_W'(INIT_NICKELS);
          dime_d       = CNT_W'(INIT_DIMES);
          doubledime_d = CNT_W'(INIT_DOUBLEDIMES);
        end else if (req_valid) begin
          remaining_d = req_amount;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        // Greedy pick, skipping coin types whose inventory is exhausted.
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else if (remaining_q >= VAL_DOUBLEDIME && doubledime_q != '0) begin
          coin_d  = COIN_DOUBLEDIME;
          state_d = ST_PULSE;
        end else if (remaining_q >= VAL_DIME && dime_q != '0) begin
          coin_d  = COIN_DIME;
          state_d = ST_PULSE;
        end else if (nickel_q != '0) begin
          coin_d  = COIN_NICKEL;
          state_d = ST_PULSE;
        end else begin
          state_d = ST_SHORT;
        end
      end
      ST_PULSE: begin
        remaining_d = remaining_q - coin_value(coin_q);
        case (coin_q)
          COIN_DOUBLEDIME: doubledime_d = doubledime_q - CNT_W'(1);
          COIN_DIME:       dime_d       = dime_q - CNT_W'(1);
          default:         nickel_d     = nickel_q - CNT_W'(1);
        endcase
        gap_d   = '0;
        state_d = (PULSE_GAP > 0) ? ST_GAP : ST_SELECT;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_SELECT;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_SHORT: begin
        remaining_d = '0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // refill gates req_ready directly so a refill cycle never accepts a request.
  assign req_ready       = (state_q == ST_IDLE) && !refill;
  assign give_nickel     = (state_q == ST_PULSE) && (coin_q == COIN_NICKEL);
  assign give_dime       = (state_q == ST_PULSE) && (coin_q == COIN_DIME);
  assign give_doubledime = (state_q == ST_PULSE) && (coin_q == COIN_DOUBLEDIME);
  assign done            = (state_q == ST_DONE);
  assign short           = (state_q == ST_SHORT);
  assign nickel_cnt      = nickel_q;
  assign dime_cnt        = dime_q;
  assign doubledime_cnt  = doubledime_q;

`ifdef VEND_CHANGE_STATS_EN
  logic [15:0] paid_total_q;
  logic [7:0]  short_total_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      paid_total_q  <= '0;
      short_total_q <= '0;
    end else begin
      if (state_q == ST_PULSE) paid_total_q  <= paid_total_q + 16'(coin_value(coin_q));
      if (state_q == ST_SHORT) short_total_q <= short_total_q + 8'd1;
    end
  end

  assign paid_total  = paid_total_q;
  assign short_total = short_total_q;
`endif

endmodule

// File: tb/tb_vend_change_sequencer.sv
// Self-checking bench for vend_change_sequencer: a transaction-level model
// expands each accepted request into a per-cycle expected timeline.
module tb_vend_change_sequencer;

  localparam int AMT_W = 4;
  localparam int CNT_W = 6;
  localparam int INIT_N = 10;
  localparam int INIT_D = 10;
  localparam int INIT_DD = 10;
  localparam int GAP = 1;

  logic             clock;
  logic             reset;
  logic             req_valid;
  logic [AMT_W-1:0] req_amount;
  logic             req_ready;
  logic             refill;
  logic             give_nickel, give_dime, give_doubledime, done, short;
  logic [CNT_W-1:0] nickel_cnt, dime_cnt, doubledime_cnt;

  vend_change_sequencer #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_NICKELS(INIT_N), .INIT_DIMES(INIT_D),
    .INIT_DOUBLEDIMES(INIT_DD), .PULSE_GAP(GAP)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .refill(refill), .give_nickel(give_nickel),
    .give_dime(give_dime), .give_doubledime(give_doubledime), .done(done),
    .short(short), .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt),
    .doubledime_cnt(doubledime_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit idle;
    bit gn, gd, gdd, dn, sh;
    int n, d, dd;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int inv_n, inv_d, inv_dd;

  function automatic exp_t mk(bit idle, bit gn, bit gd, bit gdd, bit dn, bit sh,
                              int n, int d, int dd);
    exp_t e;
    e.idle = idle; e.gn = gn; e.gd = gd; e.gdd = gdd; e.dn = dn; e.sh = sh;
    e.n = n; e.d = d; e.dd = dd;
    return e;
  endfunction

  // Expand one accepted request into the cycles that follow the accepting edge.
  task automatic plan(input int amt);
    int rem = amt;
    int n = inv_n, d = inv_d, dd = inv_dd;
    int v;
    q.push_back(mk(0, 0, 0, 0, 0, 0, n, d, dd));
    while (1) begin
      if (rem == 0) begin
        q.push_back(mk(0, 0, 0, 0, 1, 0, n, d, dd));
        break;
      end
      if (rem >= 4 && dd > 0)      v = 4;
      else if (rem >= 2 && d > 0)  v = 2;
      else if (rem >= 1 && n > 0)  v = 1;
      else begin
        q.push_back(mk(0, 0, 0, 0, 0, 1, n, d, dd));
        break;
      end
      q.push_back(mk(0, v == 1, v == 2, v == 4, 0, 0, n, d, dd));
      if (v == 4) dd--; else if (v == 2) d--; else n--;
      rem -= v;
      for (int g = 0; g < GAP; g++) q.push_back(mk(0, 0, 0, 0, 0, 0, n, d, dd));
      q.push_back(mk(0, 0, 0, 0, 0, 0, n, d, dd));
    end
    inv_n = n; inv_d = d; inv_dd = dd;
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        q.delete();
        inv_n = INIT_N; inv_d = INIT_D; inv_dd = INIT_DD;
        cur = mk(1, 0, 0, 0, 0, 0, inv_n, inv_d, inv_dd);
      end else if (cur.idle) begin
        if (refill) begin
          inv_n = INIT_N; inv_d = INIT_D; inv_dd = INIT_DD;
          cur = mk(1, 0, 0, 0, 0, 0, inv_n, inv_d, inv_dd);
        end else if (req_valid) begin
          plan(int'(req_amount));
          cur = q.pop_front();
        end
      end else if (q.size() > 0) begin
        cur = q.pop_front();
      end else begin
        cur = mk(1, 0, 0, 0, 0, 0, inv_n, inv_d, inv_dd);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [31:0] act, exp;
    forever begin
      @(negedge clock);
      if (chk_en) begin
        exp = {8'h0, cur.idle && !refill, cur.gn, cur.gd, cur.gdd, cur.dn, cur.sh,
               CNT_W'(cur.n), CNT_W'(cur.d), CNT_W'(cur.dd)};
        act = {8'h0, req_ready, give_nickel, give_dime, give_doubledime, done, short,
               nickel_cnt, dime_cnt, doubledime_cnt};
        check("cycle", act, exp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int amt);
    @(posedge clock); #2;
    req_valid  = 1'b1;
    req_amount = AMT_W'(amt);
    @(posedge clock); #2;
    req_valid  = 1'b0;
  endtask

  task automatic wait_end(output int nn, output int nd, output int ndd,
                          output bit gdone, output bit gshort);
    bit ended = 1'b0;
    nn = 0; nd = 0; ndd = 0; gdone = 1'b0; gshort = 1'b0;
    for (int i = 0; i < 200 && !ended; i++) begin
      @(negedge clock);
      nn  += int'(give_nickel);
      nd  += int'(give_dime);
      ndd += int'(give_doubledime);
      if (done)  gdone  = 1'b1;
      if (short) gshort = 1'b1;
      if (done || short) ended = 1'b1;
    end
    if (!ended) check("wait_end_timeout", 32'(ended), 32'd1);
  endtask

  task automatic run_req(input int amt, output int nn, output int nd, output int ndd,
                         output bit gdone, output bit gshort);
    issue(amt);
    wait_end(nn, nd, ndd, gdone, gshort);
  endtask

  task automatic do_refill();
    @(posedge clock); #2;
    refill = 1'b1;
    @(posedge clock); #2;
    refill = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int nn, nd, ndd;
    bit gdone, gshort;
    reset = 1'b0; req_valid = 1'b0; req_amount = '0; refill = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clock);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_counts", {14'h0, nickel_cnt, dime_cnt, doubledime_cnt}, {14'h0, 6'd10, 6'd10, 6'd10});

    // 1: 35c -> doubledime, dime, nickel at T+2/T+5/T+8, done at T+11
    issue(7);
    repeat (2) @(negedge clock);
    check("t1_dd_at_T2", 32'(give_doubledime), 32'd1);
    repeat (3) @(negedge clock);
    check("t1_d_at_T5", 32'(give_dime), 32'd1);
    repeat (3) @(negedge clock);
    check("t1_n_at_T8", 32'(give_nickel), 32'd1);
    repeat (3) @(negedge clock);
    check("t1_done_at_T11", 32'(done), 32'd1);
    check("t1_counts", {14'h0, nickel_cnt, dime_cnt, doubledime_cnt}, {14'h0, 6'd9, 6'd9, 6'd9});

    // 2: zero amount -> done at T+2, ready at T+3
    issue(0);
    repeat (2) @(negedge clock);
    check("t2_done_at_T2", {29'h0, done, give_nickel || give_dime || give_doubledime, short}, 32'h4);
    @(negedge clock);
    check("t2_ready_at_T3", 32'(req_ready), 32'd1);

    // 3: drain doubledimes, then 20c paid as two dimes
    do_refill();
    for (int i = 0; i < 10; i++) run_req(4, nn, nd, ndd, gdone, gshort);
    run_req(4, nn, nd, ndd, gdone, gshort);
    check("t3_coins", {nn[7:0], nd[7:0], ndd[7:0], 8'(gdone)}, {8'd0, 8'd2, 8'd0, 8'd1});
    check("t3_counts", {14'h0, nickel_cnt, dime_cnt, doubledime_cnt}, {14'h0, 6'd10, 6'd8, 6'd0});

    // 4: no nickels, 25c owed -> one doubledime then short
    do_refill();
    for (int i = 0; i < 10; i++) run_req(1, nn, nd, ndd, gdone, gshort);
    check("t4_nickels_drained", 32'(nickel_cnt), 32'd0);
    run_req(5, nn, nd, ndd, gdone, gshort);
    check("t4_coins", {nn[7:0], nd[7:0], ndd[7:0], 8'h0}, {8'd0, 8'd0, 8'd1, 8'h0});
    check("t4_short_not_done", {30'h0, gshort, gdone}, 32'h2);
    check("t4_dd_cnt", 32'(doubledime_cnt), 32'd9);

    // 5: reset in the middle of a PULSE cycle
    issue(6);
    repeat (2) @(negedge clock);
    check("t5_in_pulse", 32'(give_doubledime), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("t5_gives_dropped", {29'h0, give_nickel, give_dime, give_doubledime}, 32'h0);
    check("t5_no_done_short", {30'h0, done, short}, 32'h0);
    check("t5_counts_init", {14'h0, nickel_cnt, dime_cnt, doubledime_cnt}, {14'h0, 6'd10, 6'd10, 6'd10});
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("t5_idle_after", {31'h0, req_ready}, 32'h1);

    // 6: refill ignored in GAP, honoured in IDLE, concurrent request deferred
    issue(3);
    @(posedge clock); #2;
    @(posedge clock); #2;
    refill = 1'b1;
    @(posedge clock); #2;
    refill = 1'b0;
    @(negedge clock);
    check("t6_gap_refill_ignored", 32'(dime_cnt), 32'd9);
    wait_end(nn, nd, ndd, gdone, gshort);
    check("t6_first_done", {14'h0, nickel_cnt, dime_cnt, doubledime_cnt}, {14'h0, 6'd9, 6'd9, 6'd10});
    @(posedge clock); #2;
    refill = 1'b1; req_valid = 1'b1; req_amount = AMT_W'(2);
    @(negedge clock);
    check("t6_ready_low_on_refill", 32'(req_ready), 32'd0);
    @(posedge clock); #2;
    refill = 1'b0;
    @(negedge clock);
    check("t6_refilled", {14'h0, nickel_cnt, dime_cnt, doubledime_cnt}, {14'h0, 6'd10, 6'd10, 6'd10});
    check("t6_ready_next_cycle", 32'(req_ready), 32'd1);
    @(posedge clock); #2;
    req_valid = 1'b0;
    @(negedge clock);
    check("t6_accepted", 32'(req_ready), 32'd0);
    wait_end(nn, nd, ndd, gdone, gshort);
    check("t6_second_done", {nd[7:0], 8'(gdone), 10'h0, dime_cnt}, {8'd1, 8'd1, 10'h0, 6'd9});

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
